// File: rtl/register_file_mp.sv
// Parametrised 2-read / 1-write register file for the MIPS datapath with a sequenced clear on reset.
// Optional write-first forwarding is enabled by defining RF_BYPASS_EN.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [WIDTH-1:0]  rg [DEPTH];
  logic              wr_ok;

  assign busy  = (state_reg == CLEAR);
  assign wr_ok = we3 && !busy && !(ZERO_REG && (a3 == '0));

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
        state_next = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // The clear walk owns the write port while busy; user writes are dropped then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        rg[clr_cnt_reg] <= '0;
      end else if (wr_ok) begin
        rg[a3] <= wd3;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [WIDTH-1:0]  rdata;

      assign ra = (gi == 0) ? a1 : a2;

      always_comb begin
        rdata = rg[ra];
        if (busy) begin
          rdata = '0;
        end else if (ZERO_REG && (ra == '0)) begin
          rdata = '0;
        end
`ifdef RF_BYPASS_EN
        else if (wr_ok && (ra == a3)) begin
          rdata = wd3;
        end
`else
`endif
      end
    end
  endgenerate

  assign rd1 = g_rd[0].rdata;
  assign rd2 = g_rd[1].rdata;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: clear sequencing, reads/writes, zero register and a narrow build.
module tb_register_file_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, z_rd1, z_rd2;
  logic        busy, z_busy;

  logic        s_we3;
  logic [2:0]  s_a1, s_a2, s_a3;
  logic [15:0] s_wd3, s_rd1, s_rd2;
  logic        s_busy;

  int checks = 0;
  int errors = 0;

  register_file_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  register_file_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_z (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .rd1(z_rd1), .rd2(z_rd2), .busy(z_busy)
  );

  register_file_mp #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut_s (
    .clk(clk), .reset(reset), .we3(s_we3), .a1(s_a1), .a2(s_a2), .a3(s_a3),
    .wd3(s_wd3), .rd1(s_rd1), .rd2(s_rd2), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ez1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high after reset is released; bounded so a stuck FSM still ends.
  task automatic count_clear(output int n, output int sn, output bit rd_nonzero);
    n = 0;
    sn = 0;
    rd_nonzero = 1'b0;
    while ((busy || s_busy) && n < 100) begin
      if (rd1 !== 32'h0 || rd2 !== 32'h0) rd_nonzero = 1'b1;
      if (s_busy) sn++;
      if (busy) n++;
      if (we3) a3 = (a3 == 5'd5) ? 5'd9 : ((a3 == 5'd9) ? 5'd31 : 5'd5);
      tick();
    end
  endtask

  initial begin
    int n, sn;
    bit nz;

    vecs[0] = '{1'b1, 5'd0,  5'd0,  5'd5,  32'h12345678, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd5,  5'd5,  5'd0,  32'h0, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[2] = '{1'b0, 5'd6,  5'd4,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 5'd0,  5'd5,  5'd0,  32'hFFFFFFFF, 32'h0, 32'h12345678,
                BYP ? 32'hFFFFFFFF : 32'h0};
    vecs[4] = '{1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 5'd9,  5'd3,  5'd9,  32'h1, BYP ? 32'h1 : 32'h0, 32'h0,
                BYP ? 32'h1 : 32'h0};
    vecs[6] = '{1'b1, 5'd9,  5'd9,  5'd9,  32'h2, BYP ? 32'h2 : 32'h1,
                BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
    vecs[7] = '{1'b0, 5'd9,  5'd5,  5'd0,  32'h0, 32'h2, 32'h12345678, 32'h2};
    vecs[8] = '{1'b1, 5'd31, 5'd30, 5'd31, 32'hA5A5A5A5, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0,
                BYP ? 32'hA5A5A5A5 : 32'h0};
    vecs[9] = '{1'b0, 5'd30, 5'd31, 5'd0,  32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};

    reset = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    s_we3 = 1'b0; s_a1 = '0; s_a2 = '0; s_a3 = '0; s_wd3 = '0;

    // Power-up reset and first clear walk
    tick();
    check("reset_busy", 32'(busy), 32'h1);
    check("reset_rd1", rd1, 32'h0);
    reset = 1'b0;
    count_clear(n, sn, nz);
    check("init_clear_len", n, 32);
    check("init_clear_len_w16", sn, 8);

    // Preload reg 7, then a one-cycle reset must clear it
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
    tick();
    we3 = 1'b0; a1 = 5'd7; #1;
    check("preload_rd1", rd1, 32'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("pulse_busy", 32'(busy), 32'h1);
    count_clear(n, sn, nz);
    check("pulse_clear_len", n, 32);
    check("pulse_rd_zero_while_busy", 32'(nz), 32'h0);
    check("pulse_busy_after", 32'(busy), 32'h0);
    check("pulse_rd1_after", rd1, 32'h0);

    // Table-driven read/write vectors; outputs checked before each edge
    for (int i = 0; i < 10; i++) begin
      we3 = vecs[i].we3; a1 = vecs[i].a1; a2 = vecs[i].a2;
      a3 = vecs[i].a3;   wd3 = vecs[i].wd3;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      check($sformatf("vec%0d_z_rd1", i), z_rd1, vecs[i].ez1);
      tick();
    end
    we3 = 1'b0;

    // Reset mid-clear restarts the walk; writes during busy are dropped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hCAFEF00D;
    for (int i = 0; i < 10; i++) tick();
    check("midclear_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_clear(n, sn, nz);
    check("midclear_restart_len", n, 32);
    we3 = 1'b0; a1 = 5'd5; a2 = 5'd9; #1;
    check("midclear_rd1_reg5", rd1, 32'h0);
    check("midclear_rd2_reg9", rd2, 32'h0);
    a1 = 5'd31; a2 = 5'd7; #1;
    check("midclear_rd1_reg31", rd1, 32'h0);
    check("midclear_rd2_reg7", rd2, 32'h0);

    // Narrow build: 16-bit data, 8 registers
    s_we3 = 1'b1; s_a3 = 3'd7; s_wd3 = 16'hABCD;
    tick();
    s_we3 = 1'b0; s_a2 = 3'd7; s_a1 = 3'd6; #1;
    check("w16_rd2_reg7", 32'(s_rd2), 32'h0000ABCD);
    check("w16_rd1_reg6", 32'(s_rd1), 32'h0);
    s_we3 = 1'b1; s_a3 = 3'd0; s_wd3 = 16'hFFFF;
    tick();
    s_we3 = 1'b0; s_a1 = 3'd0; #1;
    check("w16_zero_reg", 32'(s_rd1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
